wishbone_master: RTL

WISHBONE_MASTER -- requirements
Module: wishbone_master

---
 rtl/wishbone_master.sv | 90 +++++++++
 1 files changed

// File: rtl/wishbone_master.sv
// Single-outstanding Wishbone master: turns one host request into one bus cycle,
// with an optional ack timeout and a RELEASE state that waits out long slave acks.
`timescale 1ns/1ps
module wishbone_master #(
    parameter logic [15:0] TIMEOUT = 16'd1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [4:0]  req_adr,
    input  logic [63:0] req_data,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [63:0] rsp_data,
    output logic        rsp_err,
    output logic        strobe_o,
    output logic        we_o,
    output logic [4:0]  adr_o,
    output logic [63:0] wb_data_o,
    input  logic [63:0] wb_data_i,
    input  logic        ack_i
);

    typedef enum logic [1:0] {IDLE, BUS, RELEASE} state_t;

    state_t      state;
    logic [15:0] wait_cnt;
    logic        timeout_hit;

    // Fires during the TIMEOUT-th unacknowledged BUS cycle, so strobe_o is high exactly TIMEOUT cycles.
    assign timeout_hit = (TIMEOUT != 16'd0) && ((wait_cnt + 16'd1) == TIMEOUT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= 16'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= 64'd0;
            rsp_err   <= 1'b0;
            strobe_o  <= 1'b0;
            we_o      <= 1'b0;
            adr_o     <= 5'd0;
            wb_data_o <= 64'd0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state     <= BUS;
                        wait_cnt  <= 16'd0;
                        req_ready <= 1'b0;
                        strobe_o  <= 1'b1;
                        we_o      <= req_we;
                        adr_o     <= req_adr;
                        wb_data_o <= req_we ? req_data : 64'd0;
                    end
                end
                BUS: begin
                    // Ack is tested first so it wins over a coincident timeout.
                    if (ack_i || timeout_hit) begin
                        state     <= RELEASE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= !ack_i;
                        rsp_data  <= (ack_i && !we_o) ? wb_data_i : 64'd0;
                        strobe_o  <= 1'b0;
                        we_o      <= 1'b0;
                        adr_o     <= 5'd0;
                        wb_data_o <= 64'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                RELEASE: begin
                    if (!ack_i) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    strobe_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule
